// File: rtl/compress_ctrl.sv
// Three-stage block pipeline controller with a beat FSM that emits one compressed beat or two raw half-beats per block.
// Latency: a block accepted in cycle N is presented at N+3. Backpressure ripples back from out_ready through the occupancy bits to in_ready.
module compress_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [2:0]       stage_en,
  input  logic             commit_compressable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_flag,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_comp,
  output logic [CNT_W-1:0] cnt_raw
);

  typedef enum logic [1:0] {IDLE, COMP, RAW0, RAW1} state_e;

  state_e           state_q, state_d, load_state;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [CNT_W-1:0] cnt_comp_q, cnt_comp_d, cnt_raw_q, cnt_raw_d;
  logic             last_acc, adv1, adv2, adv3;

  always_comb begin
    out_valid = (state_q != IDLE);
    case (state_q)
      COMP:    out_flag = 2'b01;
      RAW0:    out_flag = 2'b10;
      RAW1:    out_flag = 2'b11;
      default: out_flag = 2'b00;
    endcase
    last_acc = out_valid & out_ready & ((state_q == COMP) | (state_q == RAW1));
    adv3     = v2_q & (~v3_q | last_acc);
    adv2     = v1_q & (~v2_q | adv3);
    adv1     = in_valid & (~v1_q | adv2);
    in_ready = ~flush & (~v1_q | adv2);
    stage_en = flush ? 3'b000 : {adv3, adv2, adv1};
    busy     = v1_q | v2_q | v3_q;
    cnt_comp = cnt_comp_q;
    cnt_raw  = cnt_raw_q;
  end

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (adv1)          v1_d = 1'b1;
    else if (adv2)     v1_d = 1'b0;
    if (adv2)          v2_d = 1'b1;
    else if (adv3)     v2_d = 1'b0;
    if (adv3)          v3_d = 1'b1;
    else if (last_acc) v3_d = 1'b0;

    // The compressable bit is only looked at while the block moves into stage 3.
    load_state = adv3 ? (commit_compressable ? COMP : RAW0) : IDLE;
    state_d    = state_q;
    case (state_q)
      IDLE:       state_d = load_state;
      COMP, RAW1: if (last_acc) state_d = load_state;
      RAW0:       if (out_ready) state_d = RAW1;
      default:    state_d = IDLE;
    endcase

    cnt_comp_d = cnt_comp_q;
    cnt_raw_d  = cnt_raw_q;
    if (!flush && out_ready && state_q == COMP && cnt_comp_q != '1)
      cnt_comp_d = cnt_comp_q + CNT_W'(1);
    if (!flush && out_ready && state_q == RAW1 && cnt_raw_q != '1)
      cnt_raw_d = cnt_raw_q + CNT_W'(1);

    if (flush) begin
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      v3_d    = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_comp_q <= '0;
      cnt_raw_q  <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      state_q    <= state_d;
      cnt_comp_q <= cnt_comp_d;
      cnt_raw_q  <= cnt_raw_d;
    end
  end

endmodule

// File: tb/tb_compress_ctrl.sv
// Bench for compress_ctrl: directed scenarios plus random traffic against a block-queue timing model.
module tb_compress_ctrl;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [2:0]  stage_en;
  logic        commit_compressable = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_flag;
  logic        busy;
  logic [15:0] cnt_comp;
  logic [15:0] cnt_raw;

  compress_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .stage_en(stage_en), .commit_compressable(commit_compressable), .out_valid(out_valid),
    .out_ready(out_ready), .out_flag(out_flag), .busy(busy), .cnt_comp(cnt_comp), .cnt_raw(cnt_raw)
  );

  always #5 clk = ~clk;

  // Model: blocks in flight, oldest first, each with its acceptance cycle.
  typedef struct {logic b; int acc;} blk_t;
  blk_t q[$];
  int   cyc = 0;
  int   prev_done = -100;
  bit   half = 0;
  int   m_cc = 0;
  int   m_cr = 0;
  bit   accepted_last = 0;

  int   checks = 0;
  int   errors = 0;

  logic [2:0] se_obs;
  logic       ov_obs, ir_obs, busy_obs;
  logic [1:0] fl_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    half = 0;
    prev_done = -100;
    m_cc = 0;
    m_cr = 0;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic fl, input logic bit_in);
    bit         exp_ov, exp_ir, completing;
    logic [1:0] exp_flag;
    int         start, idx;
    blk_t       nb;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    exp_ov = 0;
    if (q.size() > 0) begin
      start  = (q[0].acc + 3 > prev_done + 1) ? q[0].acc + 3 : prev_done + 1;
      exp_ov = (cyc >= start);
    end
    #1;
    // The bit is only meaningful on the load cycle; elsewhere feed noise.
    if (stage_en[2]) begin
      idx = exp_ov ? 1 : 0;
      commit_compressable = (q.size() > idx) ? q[idx].b : 1'b0;
    end else begin
      commit_compressable = 1'($urandom);
    end
    #1;
    exp_flag   = !exp_ov ? 2'b00 : (q[0].b ? 2'b01 : (half ? 2'b11 : 2'b10));
    completing = exp_ov && ordy && (q[0].b || half);
    exp_ir     = !fl && (q.size() < 3 || completing);
    se_obs = stage_en; ov_obs = out_valid; ir_obs = in_ready; busy_obs = busy; fl_obs = out_flag;
    chk("out_valid", out_valid, exp_ov);
    chk("out_flag", out_flag, exp_flag);
    chk("busy", busy, q.size() > 0);
    chk("in_ready", in_ready, exp_ir);
    chk("stage_en0", stage_en[0], iv && exp_ir);
    if (fl) chk("stage_en_flush", stage_en, 3'b000);
    chk("cnt_comp", cnt_comp, m_cc);
    chk("cnt_raw", cnt_raw, m_cr);
    accepted_last = 0;
    if (fl) begin
      q.delete();
      half = 0;
      prev_done = -100;
    end else begin
      if (exp_ov && ordy) begin
        if (q[0].b) begin
          void'(q.pop_front());
          if (m_cc < CMAX) m_cc++;
          prev_done = cyc;
        end else if (!half) begin
          half = 1;
        end else begin
          void'(q.pop_front());
          half = 0;
          if (m_cr < CMAX) m_cr++;
          prev_done = cyc;
        end
      end
      if (iv && exp_ir) begin
        nb.b = bit_in;
        nb.acc = cyc;
        q.push_back(nb);
        accepted_last = 1;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [3:0] pat;
    int         c_base, r_base, cr_save;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flag", out_flag, 2'b00);
    chk("rst_stage_en", stage_en, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt_comp", cnt_comp, 0);
    #10 rst_n = 1'b1;

    // One compressed block: stage enables walk 001,010,100, beat at N+3.
    step(1, 1, 0, 1);  chk("one_comp_se_n", se_obs, 3'b001);
    step(0, 1, 0, 0);  chk("one_comp_se_n1", se_obs, 3'b010);
    step(0, 1, 0, 0);  chk("one_comp_se_n2", se_obs, 3'b100);
    step(0, 1, 0, 0);  chk("one_comp_valid_n3", ov_obs, 1); chk("one_comp_flag_n3", fl_obs, 2'b01);
    step(0, 1, 0, 0);  chk("one_comp_cnt", cnt_comp, 1);

    // One raw block: 10 then 11; a second block is still accepted meanwhile.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);  chk("raw_flag_first", fl_obs, 2'b10); chk("raw_in_ready", ir_obs, 1);
    step(0, 1, 0, 0);  chk("raw_flag_second", fl_obs, 2'b11);
    step(0, 1, 0, 0);  chk("raw_cnt", cnt_raw, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // Four back-to-back blocks into a 10-cycle downstream stall.
    pat = 4'b1010;
    c_base = m_cc; r_base = m_cr;
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0, pat[(i < 3) ? i : 3]);
      if (i >= 3) begin
        chk("stall_in_ready", ir_obs, 0);
        chk("stall_stage_en", se_obs, 3'b000);
        chk("stall_flag_held", fl_obs, 2'b10);
      end
    end
    for (int i = 0; i < 4 && !accepted_last; i++) step(1, 1, 0, pat[3]);
    chk("stall_fourth_accepted", accepted_last, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    chk("stall_drained", busy_obs, 0);
    chk("stall_comp_count", m_cc - c_base, 2);
    chk("stall_raw_count", cnt_raw - r_base[15:0], 2);

    // Flush while the raw second half is on the bus with stages 1 and 2 full.
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);  chk("flush_pre_flag", fl_obs, 2'b10);
    cr_save = cnt_raw;
    step(0, 1, 1, 0);  chk("flush_at_raw1", fl_obs, 2'b11);
    step(0, 1, 0, 0);
    chk("flush_out_valid", ov_obs, 0);
    chk("flush_busy", busy_obs, 0);
    chk("flush_cnt_raw", cnt_raw, cr_save);

    // Random traffic with occasional flush and one asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_flag", out_flag, 2'b00);
        chk("async_rst_stage_en", stage_en, 3'b000);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_cnt_comp", cnt_comp, 0);
        chk("async_rst_cnt_raw", cnt_raw, 0);
        #1 rst_n = 1'b1;
        model_reset();
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0), 1'($urandom));
    end

    // Saturation: more than 2^16-1 compressed blocks at full throughput.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 65536; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("sat_cnt_comp", cnt_comp, 16'hFFFF);
    chk("sat_model_count", m_cc, CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/compress_ctrl.md
COMPRESS_CTRL -- requirements
Module: compress_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  a 32-pixel block is offered to the compression datapath.
REQ-005 SHALL have port in_ready  output  1  controller accepts the offered block this cycle.
REQ-006 SHALL have port flush  input  1  synchronous abort of all in-flight blocks.
REQ-007 SHALL have port stage_en  output  3  load enables: bit0 header stage, bit1 residual stage, bit2 commit stage.
REQ-008 SHALL have port commit_compressable  input  1  compressable bit of the commit-stage register, valid while stage 3 is occupied.
REQ-009 SHALL have port out_valid  output  1  a 512-bit output beat is presented.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-011 SHALL have port out_flag  output  2  beat type: 01 compressed line, 10 raw first half, 11 raw second half, 00 none.
REQ-012 SHALL have port busy  output  1  any stage occupied.
REQ-013 SHALL have ports cnt_comp and cnt_raw  output  CNT_W each  blocks emitted compressed / raw.

Function
REQ-014 SHALL track occupancy bits v1 (header), v2 (residual), v3 (commit).
REQ-015 SHALL define last_acc = out_valid & out_ready & (out_flag==01 | out_flag==11).
REQ-016 SHALL compute adv3 = v2 & (~v3 | last_acc); adv2 = v1 & (~v2 | adv3); adv1 = in_valid & (~v1 | adv2).
REQ-017 SHALL drive in_ready = ~flush & (~v1 | adv2), combinationally, independent of in_valid.
REQ-018 SHALL drive stage_en = {adv3, adv2, adv1}, each gated low while flush=1.
REQ-019 SHALL update each vk as: set on advk, cleared when its content advances and nothing refills it; v3 cleared on last_acc without adv3.
REQ-020 SHALL give latency: block accepted in cycle N with no stall -> out_valid=1 in cycle N+3.
REQ-021 SHALL sustain one block per cycle when every v3 block is compressable and out_ready is held 1.
REQ-022 SHALL run a beat FSM with states IDLE, COMP, RAW0, RAW1.
REQ-023 SHALL enter from IDLE, or from COMP/RAW1 on last_acc, the state COMP if the next v3 block has commit_compressable=1, else RAW0, or IDLE if v3 will be 0.
REQ-024 SHALL move RAW0 -> RAW1 only on out_valid & out_ready; RAW0 and RAW1 hold while out_ready=0.
REQ-025 SHALL drive out_valid=1 in COMP, RAW0, RAW1, and out_flag = 01 / 10 / 11 respectively, 00 in IDLE.
REQ-026 SHALL sample commit_compressable only on the cycle stage 3 is loaded; later changes of the input are ignored for that block.
REQ-027 SHALL keep out_flag and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment cnt_comp on a COMP acceptance and cnt_raw on a RAW1 acceptance; both saturate at all-ones.
REQ-029 SHALL, on flush=1, clear v1..v3 and return the FSM to IDLE next cycle, discarding any half-sent raw block; counters are unaffected; flush overrides in_valid and out_ready.
REQ-030 SHALL drive busy = v1 | v2 | v3.

Reset
REQ-031 SHALL, on rst_n=0 and without waiting for clk, clear v1..v3, FSM to IDLE, counters to 0, so out_valid=0, out_flag=00, stage_en=000, busy=0, in_ready=1.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-transfer drops all in-flight blocks.

Verification
REQ-033 SHALL test: one block, compressable=1, out_ready=1 -> stage_en 001,010,100 in cycles N..N+2; out_valid with flag 01 at N+3; cnt_comp=1.
REQ-034 SHALL test: one block, compressable=0 -> flags 10 then 11 on consecutive cycles; cnt_raw=1; in_ready stays 1 for a second block.
REQ-035 SHALL test: 4 back-to-back blocks, out_ready=0 for 10 cycles -> in_ready drops after the 3rd acceptance; no stage_en bit asserts during the stall; flag held; all 4 emitted in order after release.
REQ-036 SHALL test: flush during RAW1 with v1,v2 set -> next cycle out_valid=0, busy=0, cnt_raw unchanged.
REQ-037 SHALL test: cnt_comp preloaded via 65535 compressed blocks (CNT_W=16) plus 1 more -> cnt_comp=16'hFFFF.
REQ-038 SHALL test: rst_n low mid-stream between clk edges -> outputs reach reset values immediately, before the next clk edge.
